// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// - rx_state_e : receiver FSM states
// - sample/tick constants for a 16x oversampled bit period
// - maj3       : 2-of-3 majority used for bit recovery
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A   = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_B   = 9;
  localparam int LAST_TICK  = 15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to 1 so an idle-high line does not look like activity
// while reset is released.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-low reset
//   d     - asynchronous input
//   q     - synchronised output (2 clk latency)
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversample tick.
// Finds the start edge, recovers each bit by 2-of-3 majority around mid-bit,
// checks the stop bit at its midpoint and offers the word on a valid/ready
// interface.
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-low reset
//   rx_en      - oversample tick (one tick per clk with rx_en=1)
//   rx         - raw serial line, idle high, asynchronous
//   data_out   - received word, held while data_valid=1
//   data_valid - word available
//   data_ready - consumer accepts the word
//   frame_err  - one-clk pulse: stop bit sampled 0
//   overrun    - one-clk pulse: an unaccepted word was overwritten
//   busy       - receiver is not idle
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  rx_state_e            state, state_next;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           samp;
  logic                 maj_now;
  logic                 maj_bit;
  logic                 load;
  logic                 ferr;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // At tick 9 the third sample is the live synchronised line; by tick 15
  // all three samples are registered.
  assign maj_now = maj3(samp[0], samp[1], rx_s);
  assign maj_bit = maj3(samp[0], samp[1], samp[2]);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    ferr       = 1'b0;
    if (rx_en) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) state_next = START;
        end
        START: begin
          if (tick_cnt == TW'(SAMPLE_B) && maj_now) state_next = IDLE;
          else if (tick_cnt == TW'(LAST_TICK))      state_next = DATA;
        end
        DATA: begin
          if (tick_cnt == TW'(LAST_TICK) && bit_cnt == BW'(DATA_BITS - 1))
            state_next = STOP;
        end
        STOP: begin
          // Decide at mid-stop so a following start bit is not missed.
          if (tick_cnt == TW'(SAMPLE_B)) begin
            if (maj_now) begin
              load       = 1'b1;
              state_next = IDLE;
            end else begin
              ferr       = 1'b1;
              state_next = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line returns high so a break is one error.
          if (rx_s) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      samp     <= '0;
    end else if (rx_en) begin
      // Detection tick counts as tick 0, so entering START leaves tick_cnt=1.
      if (state_next == IDLE || state_next == WAIT_IDLE) tick_cnt <= '0;
      else                                               tick_cnt <= tick_cnt + TW'(1);

      if (tick_cnt == TW'(SAMPLE_A))   samp[0] <= rx_s;
      if (tick_cnt == TW'(SAMPLE_MID)) samp[1] <= rx_s;
      if (tick_cnt == TW'(SAMPLE_B))   samp[2] <= rx_s;

      if (tick_cnt == TW'(LAST_TICK)) begin
        if (state == START) begin
          bit_cnt <= '0;
        end else if (state == DATA) begin
          shreg   <= {maj_bit, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  // Output handshake: the clear runs every clk, independent of rx_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= load & data_valid & ~data_ready;
      if (load) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (DATA_BITS=8, OVERSAMPLE=16).
// The line is generated from the frame definition (start 0, data LSB first,
// stop); expected words are the bytes sent, tracked in queues.
module tb_uart_rx;

  localparam int DATA_BITS = 8;
  localparam int BIT_TICKS = 16;
  localparam int SYNC_LAT  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rx_en = 1'b0;
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  int en_div = 1;
  int en_cnt = 0;
  int cyc    = 0;

  int   vcyc, ferr_cnt, ovr_cnt, valid_cyc, fall_cyc;
  logic valid_seen, busy_at_valid, busy_before, prev_busy;
  logic [DATA_BITS-1:0] got_q[$];
  logic [DATA_BITS-1:0] exp_q[$];

  uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(BIT_TICKS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_en      (rx_en),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Tick generator: one rx_en every en_div clks, changed 2 units after posedge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    en_cnt = en_cnt + 1;
    if (en_cnt >= en_div) en_cnt = 0;
    rx_en = (en_cnt == 0);
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (data_valid) vcyc = vcyc + 1;
    if (frame_err)  ferr_cnt = ferr_cnt + 1;
    if (overrun)    ovr_cnt = ovr_cnt + 1;
    if (data_valid && data_ready) got_q.push_back(data_out);
    if (data_valid && !valid_seen) begin
      valid_seen    = 1'b1;
      valid_cyc     = cyc;
      busy_at_valid = busy;
      busy_before   = prev_busy;
    end
    prev_busy = busy;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_mon();
    vcyc       = 0;
    ferr_cnt   = 0;
    ovr_cnt    = 0;
    valid_seen = 1'b0;
    got_q.delete();
  endtask

  // Drives one frame; glitch_clk inverts the line for that single clk,
  // max_clks truncates the frame.
  task automatic send_frame(input logic [DATA_BITS-1:0] data, input logic stop_bit,
                            input int glitch_clk, input int max_clks);
    logic [DATA_BITS+1:0] fb;
    int bit_clks;
    logic b;
    fb       = {stop_bit, data, 1'b0};
    bit_clks = BIT_TICKS * en_div;
    for (int j = 0; j < (DATA_BITS + 2) * bit_clks && j < max_clks; j++) begin
      b  = fb[j / bit_clks];
      rx = (j == glitch_clk) ? ~b : b;
      if (j == 0) fall_cyc = cyc;
      step(1);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    rx         = 1'b1;
    data_ready = 1'b0;
    #1;
    if ({data_out, data_valid, frame_err, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b/%b expected all 0",
               data_out, data_valid, frame_err, overrun, busy);
    end
    checks++;
    step(3);
    reset = 1'b1;
    step(5);
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid=%b expected 0/0", busy, data_valid);
    end
    checks++;
  endtask

  task automatic test_clean();
    en_div     = 1;
    data_ready = 1'b1;
    step(4);
    clear_mon();
    send_frame(8'hA5, 1'b1, -1, 1 << 30);
    step(30);
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL clean_data: got %0d words first=%h expected 1 word a5",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
    checks++;
    if (vcyc != 1) begin
      errors++;
      $display("FAIL clean_valid_width: got %0d clks expected 1", vcyc);
    end
    checks++;
    if (ferr_cnt != 0 || ovr_cnt != 0) begin
      errors++;
      $display("FAIL clean_flags: frame_err=%0d overrun=%0d expected 0/0", ferr_cnt, ovr_cnt);
    end
    checks++;
    if (busy_at_valid !== 1'b0 || busy_before !== 1'b1) begin
      errors++;
      $display("FAIL clean_busy_fall: busy before/at valid=%b/%b expected 1/0",
               busy_before, busy_at_valid);
    end
    checks++;
    if (valid_cyc - fall_cyc != SYNC_LAT + (1 + DATA_BITS) * BIT_TICKS + 10) begin
      errors++;
      $display("FAIL clean_latency: got %0d clks expected %0d", valid_cyc - fall_cyc,
               SYNC_LAT + (1 + DATA_BITS) * BIT_TICKS + 10);
    end
    checks++;
  endtask

  task automatic test_glitch();
    logic busy_seen;
    clear_mon();
    busy_seen = 1'b0;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (busy) busy_seen = 1'b1;
    end
    if (busy_seen !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: seen=%b final=%b expected 1/0", busy_seen, busy);
    end
    checks++;
    if (vcyc != 0 || ferr_cnt != 0) begin
      errors++;
      $display("FAIL glitch_no_output: valid=%0d frame_err=%0d expected 0/0", vcyc, ferr_cnt);
    end
    checks++;
    send_frame(8'h3C, 1'b1, -1, 1 << 30);
    step(30);
    if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_recover: got %0d words first=%h expected 1 word 3c",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
    checks++;
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h5A, 1'b0, -1, 1 << 30);
    rx = 1'b0;
    step(40);
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_low: got %b expected 1", busy);
    end
    checks++;
    if (ferr_cnt != 1 || vcyc != 0) begin
      errors++;
      $display("FAIL ferr_pulse: frame_err=%0d valid=%0d expected 1/0", ferr_cnt, vcyc);
    end
    checks++;
    if (data_out !== 8'h3C) begin
      errors++;
      $display("FAIL ferr_data_kept: got %h expected 3c", data_out);
    end
    checks++;
    rx = 1'b1;
    step(40);
    if (busy !== 1'b0 || ferr_cnt != 1 || vcyc != 0) begin
      errors++;
      $display("FAIL ferr_release: busy=%b frame_err=%0d valid=%0d expected 0/1/0",
               busy, ferr_cnt, vcyc);
    end
    checks++;
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1, -1, 1 << 30);
    send_frame(8'h22, 1'b1, -1, 1 << 30);
    step(20);
    if (ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d clks expected 1", ovr_cnt);
    end
    checks++;
    if (data_out !== 8'h22 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_data: got %h valid=%b expected 22 valid=1", data_out, data_valid);
    end
    checks++;
    data_ready = 1'b1;
    step(1);
    data_ready = 1'b0;
    step(1);
    if (data_valid !== 1'b0 || got_q.size() != 1 || got_q[0] !== 8'h22) begin
      errors++;
      $display("FAIL overrun_accept: valid=%b accepted=%0d expected 0 and one 22",
               data_valid, got_q.size());
    end
    checks++;
  endtask

  task automatic test_noise();
    data_ready = 1'b1;
    en_div     = 1;
    step(4);
    clear_mon();
    send_frame(8'h0F, 1'b1, (1 + 3) * BIT_TICKS + 8, 1 << 30);
    step(30);
    if (got_q.size() != 1 || got_q[0] !== 8'h0F) begin
      errors++;
      $display("FAIL noise_majority: got %0d words first=%h expected 1 word 0f",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
    checks++;
    en_div = 4;
    step(8);
    clear_mon();
    send_frame(8'hC3, 1'b1, -1, 1 << 30);
    step(120);
    if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin
      errors++;
      $display("FAIL sparse_tick: got %0d words first=%h expected 1 word c3",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
    checks++;
    en_div = 1;
    step(4);
  endtask

  task automatic test_async_reset();
    data_ready = 1'b0;
    send_frame(8'h66, 1'b1, -1, 1 << 30);
    step(10);
    send_frame(8'h55, 1'b1, -1, 4 * BIT_TICKS);
    if (busy !== 1'b1 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: busy=%b valid=%b expected 1/1", busy, data_valid);
    end
    checks++;
    #1;
    reset = 1'b0;
    #1;
    if ({data_out, data_valid, frame_err, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL areset_immediate: got %h/%b/%b/%b/%b expected all 0",
               data_out, data_valid, frame_err, overrun, busy);
    end
    checks++;
    step(2);
    rx = 1'b1;
    step(1);
    reset      = 1'b1;
    data_ready = 1'b1;
    step(4);
    clear_mon();
    send_frame(8'h81, 1'b1, -1, 1 << 30);
    step(30);
    if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
      errors++;
      $display("FAIL areset_recover: got %0d words first=%h expected 1 word 81",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_BITS-1:0] d;
    data_ready = 1'b1;
    clear_mon();
    exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      en_div = $urandom_range(1, 3);
      d      = DATA_BITS'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1, -1, 1 << 30);
      step($urandom_range(0, 20));
    end
    step(40 * en_div);
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    checks++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
      checks++;
    end
    if (ferr_cnt != 0 || ovr_cnt != 0) begin
      errors++;
      $display("FAIL random_flags: frame_err=%0d overrun=%0d expected 0/0", ferr_cnt, ovr_cnt);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_noise();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
